// File: rtl/seq_shifter.sv
// Multi-cycle shift unit for the execute stage: one bit per clock under a start/busy/done handshake.
// Optional SEQ_SHIFTER_ONECYCLE_EN swaps the iterative path for a single-edge barrel shifter.
module seq_shifter #(
  parameter int unsigned N       = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [N-1:0]       data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [N-1:0]       Shift_out,
  output logic               carry_out
);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [N-1:0]         r_work;
  logic [N-1:0]         w_work_nxt;
  logic [SHAMT_W-1:0]   r_cnt;
  logic [SHAMT_W-1:0]   w_cnt_nxt;
  logic [1:0]           r_op;
  logic [1:0]           w_op_nxt;
  logic                 r_carry;
  logic                 w_carry_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic [N-1:0]         w_shift_out_nxt;
  logic                 w_carry_out_nxt;

`ifdef SEQ_SHIFTER_ONECYCLE_EN
  // Full-amount barrel result; the extra bit of each extension holds the last bit shifted out.
  logic [N:0]         w_lsl_ext;
  logic [N:0]         w_lsr_ext;
  logic signed [N:0]  w_asr_ext;
  logic [31:0]        w_rot_amt;
  logic [N-1:0]       w_ror;
  logic [N-1:0]       w_bar_res;
  logic               w_bar_carry;

  always_comb begin
    w_lsl_ext   = {1'b0, r_work} << r_cnt;
    w_lsr_ext   = {r_work, 1'b0} >> r_cnt;
    w_asr_ext   = $signed({r_work, 1'b0}) >>> r_cnt;
    w_rot_amt   = 32'(r_cnt) % N;
    w_ror       = N'({r_work, r_work} >> w_rot_amt);
    w_bar_res   = w_ror;
    w_bar_carry = (r_cnt != '0) & w_ror[N-1];
    case (r_op)
      OP_LSL: begin
        w_bar_res   = w_lsl_ext[N-1:0];
        w_bar_carry = w_lsl_ext[N];
      end
      OP_LSR: begin
        w_bar_res   = w_lsr_ext[N:1];
        w_bar_carry = w_lsr_ext[0];
      end
      OP_ASR: begin
        w_bar_res   = w_asr_ext[N:1];
        w_bar_carry = w_asr_ext[0];
      end
      default: ;
    endcase
  end
`else
  logic [N-1:0] w_step_work;
  logic         w_step_carry;

  // Single-position step of the iterative datapath.
  always_comb begin
    w_step_work  = {r_work[0], r_work[N-1:1]};
    w_step_carry = r_work[0];
    case (r_op)
      OP_LSL: begin
        w_step_work  = {r_work[N-2:0], 1'b0};
        w_step_carry = r_work[N-1];
      end
      OP_LSR:  w_step_work = {1'b0, r_work[N-1:1]};
      OP_ASR:  w_step_work = {r_work[N-1], r_work[N-1:1]};
      default: ;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_work_nxt      = r_work;
    w_cnt_nxt       = r_cnt;
    w_op_nxt        = r_op;
    w_carry_nxt     = r_carry;
    w_busy_nxt      = busy;
    w_done_nxt      = 1'b0;
    w_shift_out_nxt = Shift_out;
    w_carry_out_nxt = carry_out;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_work_nxt  = data_in;
          w_cnt_nxt   = shamt;
          w_op_nxt    = op;
          w_carry_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
`ifdef SEQ_SHIFTER_ONECYCLE_EN
        w_shift_out_nxt = w_bar_res;
        w_carry_out_nxt = w_bar_carry;
        w_done_nxt      = 1'b1;
        w_busy_nxt      = 1'b0;
        w_state_nxt     = ST_IDLE;
`else
        if (r_cnt != '0) begin
          w_work_nxt  = w_step_work;
          w_carry_nxt = w_step_carry;
          w_cnt_nxt   = r_cnt - SHAMT_W'(1);
        end else begin
          w_shift_out_nxt = r_work;
          w_carry_out_nxt = r_carry;
          w_done_nxt      = 1'b1;
          w_busy_nxt      = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work    <= '0;
      r_cnt     <= '0;
      r_op      <= '0;
      r_carry   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      Shift_out <= '0;
      carry_out <= 1'b0;
    end else begin
      r_work    <= w_work_nxt;
      r_cnt     <= w_cnt_nxt;
      r_op      <= w_op_nxt;
      r_carry   <= w_carry_nxt;
      busy      <= w_busy_nxt;
      done      <= w_done_nxt;
      Shift_out <= w_shift_out_nxt;
      carry_out <= w_carry_out_nxt;
    end
  end

endmodule
